// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for the DDS waveform source.
//   MODE_*   waveform select encodings carried with every sample
//   FTW_RST  active tuning word after reset (generator parked)
//   AMP_RST  active amplitude after reset (full scale)
//   LAT      sample_en -> dac_valid latency for the default ROM latency
package dds_pkg;

  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SAW    = 2'd3;

  localparam int ACC_W_DEF   = 32;
  localparam int AMP_W_DEF   = 8;
  localparam int ROM_LAT_DEF = 1;

  localparam logic [ACC_W_DEF-1:0] FTW_RST = '0;
  localparam logic [AMP_W_DEF-1:0] AMP_RST = '1;

  // S1 (rom_addr) + ROM stages + shape/scale register + output register
  localparam int LAT = ROM_LAT_DEF + 3;

  function automatic int unsigned pipe_lat(input int unsigned rom_lat);
    return rom_lat + 3;
  endfunction

endpackage

// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper: selects the raw waveform value for one sample and scales
// it around midscale by amp / 2^AMP_W, with one register stage.
//   clk, rst_n      clock, synchronous active-low reset
//   smp_valid       sample present at the shaper input this cycle
//   mode, amp       per-sample waveform mode and amplitude word
//   phase_top       top DATA_W+1 bits of the phase index of the sample
//   carry           accumulator carry of the sample
//   rom_q           sine ROM data aligned with this sample
//   shaped_valid    registered sample strobe
//   shaped_data     registered scaled sample (held between samples)
//   shaped_carry    registered carry, qualified by shaped_valid
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AMP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smp_valid,
  input  logic [1:0]        mode,
  input  logic [AMP_W-1:0]  amp,
  input  logic [DATA_W:0]   phase_top,
  input  logic              carry,
  input  logic [DATA_W-1:0] rom_q,
  output logic              shaped_valid,
  output logic [DATA_W-1:0] shaped_data,
  output logic              shaped_carry
);

  localparam int PROD_W = DATA_W + AMP_W + 2;
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]        raw;
  logic [DATA_W-1:0]        scaled;
  logic signed [DATA_W:0]   centered;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;

  always_comb begin
    raw = '0;
    unique case (mode)
      MODE_SINE:   raw = rom_q;
      MODE_SQUARE: raw = phase_top[DATA_W] ? '0 : '1;
      // triangle uses one phase bit below the saw slice so it spans full scale per half period
      MODE_TRI:    raw = phase_top[DATA_W] ? ~phase_top[DATA_W-1:0] : phase_top[DATA_W-1:0];
      default:     raw = phase_top[DATA_W:1];
    endcase

    centered = $signed({1'b0, raw}) - $signed({1'b0, MIDSCALE});
    prod     = PROD_W'(centered) * PROD_W'($signed({1'b0, amp}));
    // arithmetic shift floors toward -inf; the result always lands inside the code range
    prod_sh  = prod >>> AMP_W;
    scaled   = DATA_W'(prod_sh + PROD_W'(MIDSCALE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shaped_valid <= 1'b0;
      shaped_data  <= MIDSCALE;
      shaped_carry <= 1'b0;
    end else begin
      shaped_valid <= smp_valid;
      shaped_carry <= smp_valid & carry;
      if (smp_valid) begin
        shaped_data <= scaled;
      end
    end
  end

endmodule

// File: rtl/dds_signal_gen.sv
// dds_signal_gen: single-channel DDS source (sine/square/triangle/saw).
//   clk, rst_n         clock, synchronous active-low reset
//   sample_en          one-cycle strobe, takes one sample from the accumulator
//   cfg_valid/ready    config handshake; ready is low while a config is pending
//   cfg_ftw/phase/mode/amp/apply_now   config word fields
//   rom_addr, rom_q    external sine ROM, data ROM_LAT cycles after address
//   dac_data           registered output sample, held between samples
//   dac_valid          one-cycle strobe per output sample
//   wrap_pulse         set with dac_valid of a sample whose accumulator add carried
module dds_signal_gen
  import dds_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 11,
  parameter int DATA_W  = 8,
  parameter int AMP_W   = 8,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [1:0]         cfg_mode,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic               cfg_apply_now,
  output logic [PHASE_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]  rom_q,
  output logic [DATA_W-1:0]  dac_data,
  output logic               dac_valid,
  output logic               wrap_pulse
);

  localparam int TOP_W = DATA_W + 1;
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  // active configuration
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_act;
  logic [PHASE_W-1:0] phase_act;
  logic [1:0]         mode_act;
  logic [AMP_W-1:0]   amp_act;

  // shadow configuration
  logic [ACC_W-1:0]   ftw_sh;
  logic [PHASE_W-1:0] phase_sh;
  logic [1:0]         mode_sh;
  logic [AMP_W-1:0]   amp_sh;
  logic               now_sh;
  logic               pending;

  logic [ACC_W:0]     acc_sum;
  logic [PHASE_W-1:0] idx;
  logic               wrap_hit;
  logic               do_apply;
  logic               do_capture;

  // per-sample metadata aligned with the ROM read; entry 0 is the S1 stage
  logic [ROM_LAT:0]   pv;
  logic [ROM_LAT:0]   pc;
  logic [1:0]         pm [ROM_LAT+1];
  logic [AMP_W-1:0]   pa [ROM_LAT+1];
  logic [TOP_W-1:0]   pp [ROM_LAT+1];

  logic               shaped_valid;
  logic [DATA_W-1:0]  shaped_data;
  logic               shaped_carry;

  always_comb begin
    acc_sum    = {1'b0, acc} + {1'b0, ftw_act};
    idx        = acc[ACC_W-1 -: PHASE_W] + phase_act;
    // only a wrap seen while already pending counts, so a wrap in the capture cycle is skipped
    wrap_hit   = sample_en & acc_sum[ACC_W] & pending;
    // a parked generator (ftw 0) never wraps, so it takes the new config straight away
    do_apply   = pending & (now_sh | (ftw_act == '0) | wrap_hit);
    do_capture = cfg_valid & ~pending;
  end

  assign cfg_ready = ~pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      ftw_act   <= ACC_W'(FTW_RST);
      phase_act <= '0;
      mode_act  <= MODE_SINE;
      amp_act   <= AMP_W'(AMP_RST);
      ftw_sh    <= '0;
      phase_sh  <= '0;
      mode_sh   <= MODE_SINE;
      amp_sh    <= '0;
      now_sh    <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (sample_en) begin
        acc <= acc_sum[ACC_W-1:0];
      end
      // apply and capture are mutually exclusive: one needs pending, the other !pending
      if (do_apply) begin
        ftw_act   <= ftw_sh;
        phase_act <= phase_sh;
        mode_act  <= mode_sh;
        amp_act   <= amp_sh;
        pending   <= 1'b0;
      end
      if (do_capture) begin
        ftw_sh   <= cfg_ftw;
        phase_sh <= cfg_phase;
        mode_sh  <= cfg_mode;
        amp_sh   <= cfg_amp;
        now_sh   <= cfg_apply_now;
        pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      pv       <= '0;
      pc       <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        pm[k] <= MODE_SINE;
        pa[k] <= '0;
        pp[k] <= '0;
      end
    end else begin
      pv[0] <= sample_en;
      if (sample_en) begin
        rom_addr <= idx;
        pc[0]    <= acc_sum[ACC_W];
        pm[0]    <= mode_act;
        pa[0]    <= amp_act;
        pp[0]    <= idx[PHASE_W-1 -: TOP_W];
      end
      for (int k = 1; k <= ROM_LAT; k++) begin
        pv[k] <= pv[k-1];
        pc[k] <= pc[k-1];
        pm[k] <= pm[k-1];
        pa[k] <= pa[k-1];
        pp[k] <= pp[k-1];
      end
    end
  end

  dds_wave_shaper #(
    .DATA_W (DATA_W),
    .AMP_W  (AMP_W)
  ) u_shaper (
    .clk          (clk),
    .rst_n        (rst_n),
    .smp_valid    (pv[ROM_LAT]),
    .mode         (pm[ROM_LAT]),
    .amp          (pa[ROM_LAT]),
    .phase_top    (pp[ROM_LAT]),
    .carry        (pc[ROM_LAT]),
    .rom_q        (rom_q),
    .shaped_valid (shaped_valid),
    .shaped_data  (shaped_data),
    .shaped_carry (shaped_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dac_data   <= MIDSCALE;
      dac_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      dac_valid  <= shaped_valid;
      wrap_pulse <= shaped_carry;
      if (shaped_valid) begin
        dac_data <= shaped_data;
      end
    end
  end

endmodule
